// File: rtl/picorv32_axi_bridge.sv
// PicoRV32 native memory port to AXI4-lite master bridge with BRESP/RRESP error reporting.
// Define PICORV32_AXI_BRIDGE_POSTED_WRITE_EN for posted writes with a bounded count of outstanding B responses.
module picorv32_axi_bridge #(
    parameter int         ADDR_WIDTH      = 32,
    parameter int         MAX_OUTSTANDING = 4,
    parameter logic [2:0] PROT_INSTR      = 3'b100,
    parameter logic [2:0] PROT_DATA       = 3'b000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  mem_valid,
    input  logic                  mem_instr,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,
    output logic                  mem_err,
    output logic                  err_sticky,
    input  logic                  err_clear,
    output logic                  busy,
    output logic                  mem_axi_awvalid,
    input  logic                  mem_axi_awready,
    output logic [ADDR_WIDTH-1:0] mem_axi_awaddr,
    output logic [2:0]            mem_axi_awprot,
    output logic                  mem_axi_wvalid,
    input  logic                  mem_axi_wready,
    output logic [31:0]           mem_axi_wdata,
    output logic [3:0]            mem_axi_wstrb,
    input  logic                  mem_axi_bvalid,
    output logic                  mem_axi_bready,
    input  logic [1:0]            mem_axi_bresp,
    output logic                  mem_axi_arvalid,
    input  logic                  mem_axi_arready,
    output logic [ADDR_WIDTH-1:0] mem_axi_araddr,
    output logic [2:0]            mem_axi_arprot,
    input  logic                  mem_axi_rvalid,
    output logic                  mem_axi_rready,
    input  logic [31:0]           mem_axi_rdata,
    input  logic [1:0]            mem_axi_rresp
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_WRESP = 3'd3;
    localparam logic [2:0] ST_ACK   = 3'd4;

    generate
        if (ADDR_WIDTH < 12 || ADDR_WIDTH > 64) begin : g_bad_addr_width
            $error("picorv32_axi_bridge: ADDR_WIDTH must be 12..64");
        end
        if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_max_outstanding
            $error("picorv32_axi_bridge: MAX_OUTSTANDING must be 1..15");
        end
    endgenerate

    logic [2:0]            state_q, state_d;
    logic                  arvalid_q, arvalid_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  rready_q, rready_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [2:0]            arprot_q, arprot_d;
    logic [2:0]            awprot_q, awprot_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  mem_ready_q, mem_ready_d;
    logic                  mem_err_q, mem_err_d;
    logic                  err_sticky_q, err_sticky_d;
    logic                  busy_q, busy_d;
    logic                  err_set;
    logic                  rd_ok;
    logic                  wr_ok;

`ifdef PICORV32_AXI_BRIDGE_POSTED_WRITE_EN
    localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_issue;
    logic             b_retire;
`endif

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        arvalid_d   = arvalid_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        araddr_d    = araddr_q;
        awaddr_d    = awaddr_q;
        arprot_d    = arprot_q;
        awprot_d    = awprot_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        mem_ready_d = 1'b0;
        mem_err_d   = 1'b0;
        err_set     = 1'b0;
`ifdef PICORV32_AXI_BRIDGE_POSTED_WRITE_EN
        wr_issue    = 1'b0;
        b_retire    = mem_axi_bvalid && bready_q;
        cnt_d       = cnt_q;
        rd_ok       = (cnt_q == {CNT_W{1'b0}});
        wr_ok       = (cnt_q != CNT_MAX);
`else
        rd_ok       = 1'b1;
        wr_ok       = 1'b1;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mem_valid && (mem_wstrb == 4'b0000) && rd_ok) begin
                    state_d   = ST_READ;
                    araddr_d  = mem_addr;
                    arprot_d  = mem_instr ? PROT_INSTR : PROT_DATA;
                    arvalid_d = 1'b1;
                    rready_d  = 1'b1;
                end else if (mem_valid && (mem_wstrb != 4'b0000) && wr_ok) begin
                    state_d   = ST_WRITE;
                    awaddr_d  = mem_addr;
                    awprot_d  = PROT_DATA;
                    wdata_d   = mem_wdata;
                    wstrb_d   = mem_wstrb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (arvalid_q && mem_axi_arready) begin
                    arvalid_d = 1'b0;
                end else begin
                    arvalid_d = arvalid_q;
                end
                if (mem_axi_rvalid) begin
                    rdata_d     = mem_axi_rdata;
                    mem_err_d   = (mem_axi_rresp != 2'b00);
                    err_set     = (mem_axi_rresp != 2'b00);
                    arvalid_d   = 1'b0;
                    rready_d    = 1'b0;
                    mem_ready_d = 1'b1;
                    state_d     = ST_ACK;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                // AW and W retire independently; the phase ends once both valids have dropped.
                if (awvalid_q && mem_axi_awready) begin
                    awvalid_d = 1'b0;
                end else begin
                    awvalid_d = awvalid_q;
                end
                if (wvalid_q && mem_axi_wready) begin
                    wvalid_d = 1'b0;
                end else begin
                    wvalid_d = wvalid_q;
                end
                if (!awvalid_q && !wvalid_q) begin
`ifdef PICORV32_AXI_BRIDGE_POSTED_WRITE_EN
                    wr_issue    = 1'b1;
                    mem_ready_d = 1'b1;
                    state_d     = ST_ACK;
`else
                    bready_d    = 1'b1;
                    state_d     = ST_WRESP;
`endif
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRESP: begin
                if (mem_axi_bvalid) begin
                    mem_err_d   = (mem_axi_bresp != 2'b00);
                    err_set     = (mem_axi_bresp != 2'b00);
                    bready_d    = 1'b0;
                    mem_ready_d = 1'b1;
                    state_d     = ST_ACK;
                end else begin
                    state_d = ST_WRESP;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                arvalid_d = 1'b0;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                rready_d  = 1'b0;
                bready_d  = 1'b0;
            end
        endcase
`ifdef PICORV32_AXI_BRIDGE_POSTED_WRITE_EN
        // Responses retire in the background; only the sticky flag records their errors.
        bready_d = 1'b1;
        err_set  = err_set | (b_retire && (mem_axi_bresp != 2'b00));
        if (wr_issue && !b_retire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!wr_issue && b_retire && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        busy_d = (state_d != ST_IDLE) || (cnt_d != {CNT_W{1'b0}});
`else
        busy_d = (state_d != ST_IDLE);
`endif
        if (err_set) begin
            err_sticky_d = 1'b1;
        end else if (err_clear) begin
            err_sticky_d = 1'b0;
        end else begin
            err_sticky_d = err_sticky_q;
        end
    end

    // State and registered outputs; reset drops every valid immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            arvalid_q    <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            rready_q     <= 1'b0;
            araddr_q     <= {ADDR_WIDTH{1'b0}};
            awaddr_q     <= {ADDR_WIDTH{1'b0}};
            arprot_q     <= 3'b000;
            awprot_q     <= 3'b000;
            wdata_q      <= 32'h0000_0000;
            wstrb_q      <= 4'b0000;
            rdata_q      <= 32'h0000_0000;
            mem_ready_q  <= 1'b0;
            mem_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            arvalid_q    <= arvalid_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            rready_q     <= rready_d;
            araddr_q     <= araddr_d;
            awaddr_q     <= awaddr_d;
            arprot_q     <= arprot_d;
            awprot_q     <= awprot_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            rdata_q      <= rdata_d;
            mem_ready_q  <= mem_ready_d;
            mem_err_q    <= mem_err_d;
            err_sticky_q <= err_sticky_d;
            busy_q       <= busy_d;
        end
    end

`ifdef PICORV32_AXI_BRIDGE_POSTED_WRITE_EN
    // Outstanding write-response counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign mem_ready       = mem_ready_q;
    assign mem_rdata       = rdata_q;
    assign mem_err         = mem_err_q;
    assign err_sticky      = err_sticky_q;
    assign busy            = busy_q;
    assign mem_axi_awvalid = awvalid_q;
    assign mem_axi_awaddr  = awaddr_q;
    assign mem_axi_awprot  = awprot_q;
    assign mem_axi_wvalid  = wvalid_q;
    assign mem_axi_wdata   = wdata_q;
    assign mem_axi_wstrb   = wstrb_q;
    assign mem_axi_bready  = bready_q;
    assign mem_axi_arvalid = arvalid_q;
    assign mem_axi_araddr  = araddr_q;
    assign mem_axi_arprot  = arprot_q;
    assign mem_axi_rready  = rready_q;

endmodule

// File: tb/tb_picorv32_axi_bridge.sv
// Self-checking bench for picorv32_axi_bridge: vector table driven through a cycle-level AXI slave,
// scoreboard of expected completions, plus reset-abort and posted-write sequences.
module tb_picorv32_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid, mem_instr, mem_ready, mem_err, err_sticky, err_clear, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    picorv32_axi_bridge #(
        .ADDR_WIDTH(32), .MAX_OUTSTANDING(2), .PROT_INSTR(3'b100), .PROT_DATA(3'b000)
    ) dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_err(mem_err), .err_sticky(err_sticky),
        .err_clear(err_clear), .busy(busy),
        .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr),
        .mem_axi_awprot(awprot),
        .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata),
        .mem_axi_wstrb(wstrb),
        .mem_axi_bvalid(bvalid), .mem_axi_bready(bready), .mem_axi_bresp(bresp),
        .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr),
        .mem_axi_arprot(arprot),
        .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata),
        .mem_axi_rresp(rresp)
    );

    typedef struct {
        bit          we;
        bit          instr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wstrb;
        logic [1:0]  resp;
        int          aw_dly;
        int          w_dly;
        int          ar_dly;
        int          rb_dly;
        bit          clr;
        int          exp_lat;
        logic [2:0]  exp_prot;
        bit          exp_err;
        bit          exp_wfirst;
    } vec_t;

    typedef struct {
        bit          we;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    bit          posted;
    logic [31:0] last_rd;
    exp_t        sb[$];
    vec_t        vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic slave_idle();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    endtask

    // One native request against a cycle-level AXI slave with per-channel wait states.
    task automatic run_vec(input int idx, input vec_t v, output int lat, output bit w_first);
        bit   ar_done = 0, r_done = 0, aw_done = 0, w_done = 0, b_done = 0;
        bit   ar_p = 0, r_p = 0, aw_p = 0, w_p = 0, b_p = 0;
        bit   acked = 0, ar_seen = 0, aw_seen = 0, fin = 0;
        int   ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
        exp_t e;
        lat = -1;
        w_first = 0;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_instr = v.instr;
        mem_addr  = v.addr;
        mem_wdata = v.we ? v.data : 32'h0;
        mem_wstrb = v.we ? v.wstrb : 4'b0000;
        e.we    = v.we;
        e.err   = (v.we && posted) ? 1'b0 : v.exp_err;
        e.rdata = v.we ? last_rd : v.data;
        if (!v.we) last_rd = v.data;
        sb.push_back(e);
        for (int i = 1; i <= 60 && !fin; i++) begin
            @(negedge clk);
            if (ar_p) ar_done = 1;
            if (r_p)  r_done  = 1;
            if (aw_p) aw_done = 1;
            if (w_p)  w_done  = 1;
            if (b_p)  b_done  = 1;
            err_clear = 1'b0;
            if (!acked && mem_ready) begin
                acked = 1;
                lat = i;
                mem_valid = 1'b0;
                if (sb.size() == 0) begin
                    chk($sformatf("sb_empty%0d", idx), 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("rdata%0d", idx), mem_rdata, e.rdata);
                    chk($sformatf("mem_err%0d", idx), mem_err, e.err);
                end
            end
            if (arvalid && !ar_seen) begin
                ar_seen = 1;
                chk($sformatf("ar_issue%0d", idx), i, 1);
                chk($sformatf("araddr%0d", idx), araddr, v.addr);
                chk($sformatf("arprot%0d", idx), arprot, v.exp_prot);
            end
            if (awvalid && !aw_seen) begin
                aw_seen = 1;
                chk($sformatf("aw_issue%0d", idx), i, 1);
                chk($sformatf("awaddr%0d", idx), {awprot, awaddr}, {v.exp_prot, v.addr});
                chk($sformatf("wdata%0d", idx), {wvalid, wstrb, wdata}, {1'b1, v.wstrb, v.data});
            end
            if (aw_seen && awvalid && !wvalid) w_first = 1;
            arready = 1'b0;
            if (arvalid && !ar_done) begin
                if (ar_cnt >= v.ar_dly) arready = 1'b1; else ar_cnt++;
            end
            ar_p = arvalid && arready;
            rvalid = 1'b0;
            if (ar_done && !r_done) begin
                if (r_cnt >= v.rb_dly) begin
                    rvalid = 1'b1; rdata = v.data; rresp = v.resp;
                end else r_cnt++;
            end
            r_p = rvalid && rready;
            awready = 1'b0;
            if (awvalid && !aw_done) begin
                if (aw_cnt >= v.aw_dly) awready = 1'b1; else aw_cnt++;
            end
            aw_p = awvalid && awready;
            wready = 1'b0;
            if (wvalid && !w_done) begin
                if (w_cnt >= v.w_dly) wready = 1'b1; else w_cnt++;
            end
            w_p = wvalid && wready;
            bvalid = 1'b0;
            if (aw_done && w_done && !b_done) begin
                if (b_cnt >= v.rb_dly) begin
                    bvalid = 1'b1; bresp = v.resp;
                end else b_cnt++;
            end
            b_p = bvalid && bready;
            err_clear = v.clr && (r_p || b_p);
            fin = acked && (!(posted && v.we) || b_done);
        end
        if (!fin) chk($sformatf("timeout%0d", idx), 64'd1, 64'd0);
        slave_idle();
        err_clear = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic do_vec(input int idx, input vec_t v);
        int lat;
        bit wf;
        int exp_lat;
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk($sformatf("sticky_clr%0d", idx), err_sticky, 1'b0);
        run_vec(idx, v, lat, wf);
        exp_lat = (posted && v.we && v.exp_lat > 0) ? v.exp_lat - 1 : v.exp_lat;
        if (exp_lat >= 0) chk($sformatf("latency%0d", idx), lat, exp_lat);
        chk($sformatf("w_first%0d", idx), wf, v.exp_wfirst);
        @(negedge clk);
        chk($sformatf("ready_pulse%0d", idx), {mem_ready, mem_err, busy}, 3'b000);
        chk($sformatf("sticky%0d", idx), err_sticky, (v.resp != 2'b00));
    endtask

`ifdef PICORV32_AXI_BRIDGE_POSTED_WRITE_EN
    task automatic wait_rdy(input int bound, output bit got);
        got = 0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            bvalid = 1'b0;
            if (mem_ready) begin
                got = 1;
                mem_valid = 1'b0;
            end
            rvalid = rready && !arvalid;
        end
    endtask

    task automatic posted_seq();
        bit got;
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        rdata = 32'h0BAD_F00D; rresp = 2'b00; bresp = 2'b00; bvalid = 1'b0;
        @(negedge clk);
        chk("posted_bready", bready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h7000 + 32'(4 * k);
            mem_wdata = 32'(k); mem_wstrb = 4'hF;
            wait_rdy((k < 2) ? 10 : 8, got);
            chk($sformatf("posted_wr%0d", k), got, (k < 2));
        end
        chk("posted_stall_aw", {awvalid, busy}, 2'b01);
        bvalid = 1'b1;
        wait_rdy(10, got);
        chk("posted_third", got, 1'b1);
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h7100; mem_wstrb = 4'b0000;
        wait_rdy(6, got);
        chk("posted_rd_wait", {got, arvalid}, 2'b00);
        bvalid = 1'b1;
        wait_rdy(6, got);
        chk("posted_rd_wait2", {got, arvalid}, 2'b00);
        bvalid = 1'b1;
        wait_rdy(10, got);
        chk("posted_rd_done", got, 1'b1);
        chk("posted_rdata", mem_rdata, 32'h0BAD_F00D);
        last_rd = 32'h0BAD_F00D;
        @(negedge clk);
        slave_idle();
        chk("posted_idle", busy, 1'b0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
`ifdef PICORV32_AXI_BRIDGE_POSTED_WRITE_EN
        posted = 1;
`else
        posted = 0;
`endif
        //        we instr addr          data          strb resp aw w ar rb clr lat prot    err wfirst
        vecs[0] = '{0, 1, 32'h0000_1000, 32'hDEAD_BEEF, 4'h0, 2'b00, 0, 0, 0, 0, 0, 3, 3'b100, 0, 0};
        vecs[1] = '{1, 0, 32'h0000_2004, 32'h1234_5678, 4'hC, 2'b10, 3, 0, 0, 0, 0, -1, 3'b000, 1, 1};
        vecs[2] = '{1, 0, 32'h0000_2008, 32'hCAFE_F00D, 4'hF, 2'b00, 0, 0, 0, 0, 0, 4, 3'b000, 0, 0};
        vecs[3] = '{0, 0, 32'h0000_3010, 32'hA5A5_0001, 4'h0, 2'b10, 0, 0, 2, 3, 0, -1, 3'b000, 1, 0};
        vecs[4] = '{0, 0, 32'hFFFF_FFFC, 32'h1357_9BDF, 4'h0, 2'b00, 0, 0, 1, 0, 0, 4, 3'b000, 0, 0};
        vecs[5] = '{1, 0, 32'h0000_0FFC, 32'h0000_00AB, 4'h1, 2'b00, 0, 2, 0, 2, 0, -1, 3'b000, 0, 0};
        vecs[6] = '{1, 1, 32'h0000_4000, 32'hFFFF_FFFF, 4'hF, 2'b11, 1, 1, 0, 0, 0, -1, 3'b000, 1, 0};
        vecs[7] = '{0, 0, 32'h0000_5000, 32'h0F0F_0F0F, 4'h0, 2'b11, 0, 0, 0, 0, 1, 3, 3'b000, 1, 0};
        vecs[8] = '{0, 1, 32'h0000_6000, 32'h1122_3344, 4'h0, 2'b00, 0, 0, 0, 1, 0, 4, 3'b100, 0, 0};

        resetn = 1'b0;
        mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        err_clear = 1'b0;
        slave_idle();
        last_rd = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ctl", {arvalid, awvalid, wvalid, bready, rready, mem_ready, mem_err, err_sticky, busy}, 9'h000);
        chk("rst_addr", {araddr, awaddr}, 64'h0);
        chk("rst_data", {wdata, mem_rdata}, 64'h0);
        chk("rst_prot", {arprot, awprot, wstrb}, 10'h000);
        resetn = 1'b1;

        for (int i = 0; i < 9; i++) do_vec(i, vecs[i]);

        // Reset while the read address is still waiting for arready.
        @(negedge clk);
        mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h0000_3000; mem_wstrb = 4'h0;
        got = 0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clk);
            if (arvalid) got = 1;
        end
        chk("rst_pre_arvalid", got, 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk("rst_abort", {arvalid, mem_ready, busy}, 3'b000);
        chk("rst_abort_rdata", mem_rdata, 32'h0);
        mem_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        last_rd = 32'h0;
        sb.delete();
        do_vec(9, vecs[0]);
        @(negedge clk);
        chk("rst_no_reissue", {arvalid, awvalid, busy}, 3'b000);

`ifdef PICORV32_AXI_BRIDGE_POSTED_WRITE_EN
        posted_seq();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
